// File: rtl/splitstreamer_pkg.sv
// Shared definitions for the I2S-to-SPDIF sample path: stream state encoding,
// width helper and default sample geometry.
package splitstreamer_pkg;

  typedef enum logic {
    FILLING   = 1'b0,
    STREAMING = 1'b1
  } stream_state_e;

  localparam int DEFAULT_WORDSIZE = 32;
  localparam int DEFAULT_CHANNELS = 2;

  // Ceiling log2, usable in parameter and port width expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_ram_1clk.sv
// Single-clock simple dual-port RAM with registered read; a same-address
// write and read in one cycle returns the old word.
module fifo_ram_1clk import splitstreamer_pkg::*; #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/reverse_bits.sv
// Pure wiring: mirrors a W-bit word so bit 0 lands on bit W-1.
module reverse_bits #(
  parameter int W = 32
) (
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o
);

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_bit
      assign data_o[gi] = data_i[W-1-gi];
    end
  endgenerate

endmodule

// File: rtl/multichannel_sample_fifo.sv
// Frame-rate multichannel sample buffer between the I2S receiver and SPDIF
// transmitter, with prefill gating, watermarks and sticky error flags.
module multichannel_sample_fifo import splitstreamer_pkg::*; #(
  parameter int WORDSIZE    = DEFAULT_WORDSIZE,
  parameter int CHANNELS    = DEFAULT_CHANNELS,
  parameter int DEPTH       = 16,
  parameter int PREFILL     = 8,
  parameter int AF_THRESH   = 12,
  parameter int AE_THRESH   = 4,
  parameter int REVERSE_OUT = 1,
  parameter int MUTE_ON_UFL = 1
) (
  input  logic                         pin_i2s_fclk,
  input  logic                         rst,
  input  logic                         write_en,
  input  logic [CHANNELS*WORDSIZE-1:0] data_in,
  input  logic                         read_en,
  input  logic                         clear_flags,
  output logic [CHANNELS*WORDSIZE-1:0] data_out,
  output logic                         out_valid,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [clog2(DEPTH):0]        level,
  output logic                         streaming,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int AW = clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = CHANNELS * WORDSIZE;
  localparam logic [LW-1:0] DEPTH_L   = LW'(DEPTH);
  localparam logic [LW-1:0] PREFILL_L = LW'(PREFILL);
  localparam logic [LW-1:0] AF_L      = LW'(AF_THRESH);
  localparam logic [LW-1:0] AE_L      = LW'(AE_THRESH);

  stream_state_e state_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          full_q, empty_q, af_q, ae_q;
  logic          out_valid_q, mute_q, ovf_q, ufl_q;
  logic          wr_acc, rd_acc, ovf_evt, ufl_evt;
  logic [DW-1:0] ram_rd_data, lane_data;

  always_comb begin
    rd_acc  = read_en && !empty_q && (state_q == STREAMING);
    wr_acc  = write_en && (!full_q || rd_acc);
    ovf_evt = write_en && !wr_acc;
    ufl_evt = read_en && empty_q && (state_q == STREAMING);
    level_d = level_q + LW'(wr_acc) - LW'(rd_acc);
  end

  always_ff @(posedge pin_i2s_fclk) begin
    if (rst) begin
      state_q     <= FILLING;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      af_q        <= 1'b0;
      ae_q        <= 1'b1;
      out_valid_q <= 1'b0;
      mute_q      <= 1'b1;
      ovf_q       <= 1'b0;
      ufl_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_q + AW'(wr_acc);
      rd_ptr_q    <= rd_ptr_q + AW'(rd_acc);
      level_q     <= level_d;
      full_q      <= (level_d == DEPTH_L);
      empty_q     <= (level_d == '0);
      af_q        <= (level_d >= AF_L);
      ae_q        <= (level_d <= AE_L);
      out_valid_q <= rd_acc;
      // A fresh event in the same cycle as clear_flags keeps the flag set.
      ovf_q       <= ovf_evt || (ovf_q && !clear_flags);
      ufl_q       <= ufl_evt || (ufl_q && !clear_flags);
      if (rd_acc) begin
        mute_q <= 1'b0;
      end else if (ufl_evt && (MUTE_ON_UFL != 0)) begin
        mute_q <= 1'b1;
      end
      case (state_q)
        FILLING:   if (level_d >= PREFILL_L) state_q <= STREAMING;
        STREAMING: if (ufl_evt) state_q <= FILLING;
        default:   state_q <= FILLING;
      endcase
    end
  end

  fifo_ram_1clk #(
    .WIDTH (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk       (pin_i2s_fclk),
    .wr_en_i   (wr_acc),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (data_in),
    .rd_en_i   (rd_acc),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (ram_rd_data)
  );

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      if (REVERSE_OUT != 0) begin : g_rev
        reverse_bits #(.W(WORDSIZE)) u_rev (
          .data_i (ram_rd_data[gi*WORDSIZE +: WORDSIZE]),
          .data_o (lane_data[gi*WORDSIZE +: WORDSIZE])
        );
      end else begin : g_pass
        assign lane_data[gi*WORDSIZE +: WORDSIZE] = ram_rd_data[gi*WORDSIZE +: WORDSIZE];
      end
    end
  endgenerate

  // The mute register gates the RAM output so reset and underflow present zeros.
  assign data_out     = mute_q ? '0 : lane_data;
  assign out_valid    = out_valid_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign level        = level_q;
  assign streaming    = (state_q == STREAMING);
  assign overflow     = ovf_q;
  assign underflow    = ufl_q;

endmodule

// File: tb/tb_multichannel_sample_fifo.sv
// Directed bench for multichannel_sample_fifo: stereo 32-bit, depth 16,
// prefill 8, reversed output, mute on underflow.
module tb_multichannel_sample_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        write_en = 1'b0;
  logic        read_en = 1'b0;
  logic        clear_flags = 1'b0;
  logic [63:0] data_in = '0;
  logic [63:0] data_out;
  logic        out_valid, full, empty, almost_full, almost_empty;
  logic        streaming, overflow, underflow;
  logic [4:0]  level;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [63:0] sb [$];

  always #5 clk = ~clk;

  multichannel_sample_fifo #(
    .WORDSIZE(32), .CHANNELS(2), .DEPTH(16), .PREFILL(8),
    .AF_THRESH(12), .AE_THRESH(4), .REVERSE_OUT(1), .MUTE_ON_UFL(1)
  ) dut (
    .pin_i2s_fclk (clk),
    .rst          (rst),
    .write_en     (write_en),
    .data_in      (data_in),
    .read_en      (read_en),
    .clear_flags  (clear_flags),
    .data_out     (data_out),
    .out_valid    (out_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .level        (level),
    .streaming    (streaming),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] rev32(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[31-i];
    return r;
  endfunction

  function automatic logic [63:0] frame(input int i);
    logic [31:0] v;
    v = i[31:0];
    return {~v, v};
  endfunction

  function automatic logic [63:0] expo(input logic [63:0] d);
    return {rev32(d[63:32]), rev32(d[31:0])};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One bus cycle; the flags say whether the bench expects each side accepted.
  task automatic op(input bit w, input bit r, input logic [63:0] d,
                    input bit exp_wr, input bit exp_rd);
    logic [63:0] exp_d;
    exp_d = '0;
    if (exp_rd) exp_d = expo(sb.pop_front());
    if (exp_wr) sb.push_back(d);
    write_en = w;
    read_en  = r;
    data_in  = d;
    tick;
    write_en = 1'b0;
    read_en  = 1'b0;
    $display("op w=%0b r=%0b din=%h -> vld=%0b dout=%h lvl=%0d", w, r, d, out_valid, data_out, level);
    chk("out_valid", {63'd0, out_valid}, {63'd0, exp_rd});
    if (exp_rd) chk("data_out", data_out, exp_d);
  endtask

  initial begin
    // Reset state
    repeat (2) tick;
    chk("rst_level", {59'd0, level}, 64'd0);
    chk("rst_empty", {63'd0, empty}, 64'd1);
    chk("rst_ae", {63'd0, almost_empty}, 64'd1);
    chk("rst_full", {63'd0, full}, 64'd0);
    chk("rst_stream", {63'd0, streaming}, 64'd0);
    chk("rst_vld", {63'd0, out_valid}, 64'd0);
    chk("rst_dout", data_out, 64'd0);
    chk("rst_flags", {62'd0, overflow, underflow}, 64'd0);
    rst = 1'b0;

    // 1: prefill then ordered reversed readback
    for (int i = 0; i < 8; i++) begin
      op(1, 0, frame(i), 1, 0);
      if (i == 6) begin
        chk("t1_stream_l7", {63'd0, streaming}, 64'd0);
        chk("t1_level7", {59'd0, level}, 64'd7);
      end
    end
    chk("t1_stream_l8", {63'd0, streaming}, 64'd1);
    chk("t1_level8", {59'd0, level}, 64'd8);
    for (int i = 0; i < 8; i++) op(0, 1, '0, 0, 1);
    tick;
    chk("t1_idle_vld", {63'd0, out_valid}, 64'd0);
    chk("t1_hold", data_out, 64'h0000_0000_1fff_ffff_e000_0000 >> 0);
    chk("t1_empty", {63'd0, empty}, 64'd1);

    // 2: fill to full, thresholds, overflow, clear
    for (int k = 1; k <= 16; k++) begin
      op(1, 0, frame(100 + k - 1), 1, 0);
      if (k == 4)  chk("t5_ae_at4", {63'd0, almost_empty}, 64'd1);
      if (k == 5)  chk("t5_ae_at5", {63'd0, almost_empty}, 64'd0);
      if (k == 11) chk("t5_af_at11", {63'd0, almost_full}, 64'd0);
      if (k == 12) chk("t5_af_at12", {63'd0, almost_full}, 64'd1);
      if (k == 15) chk("t2_full15", {63'd0, full}, 64'd0);
    end
    chk("t2_full16", {63'd0, full}, 64'd1);
    chk("t2_level16", {59'd0, level}, 64'd16);
    op(1, 0, frame(999), 0, 0);
    chk("t2_drop_level", {59'd0, level}, 64'd16);
    chk("t2_ovf", {63'd0, overflow}, 64'd1);
    clear_flags = 1'b1;
    op(1, 0, frame(998), 0, 0);
    clear_flags = 1'b0;
    chk("t2_ovf_evt_wins", {63'd0, overflow}, 64'd1);
    clear_flags = 1'b1;
    tick;
    clear_flags = 1'b0;
    chk("t2_ovf_clr", {63'd0, overflow}, 64'd0);

    // 3: simultaneous write+read at full
    op(1, 1, frame(200), 1, 1);
    chk("t3_level", {59'd0, level}, 64'd16);
    chk("t3_ovf", {63'd0, overflow}, 64'd0);
    chk("t3_full", {63'd0, full}, 64'd1);

    // 4: drain, underflow, refill while reads are ignored
    for (int i = 0; i < 16; i++) op(0, 1, '0, 0, 1);
    chk("t4_empty", {63'd0, empty}, 64'd1);
    chk("t4_stream", {63'd0, streaming}, 64'd1);
    op(0, 1, '0, 0, 0);
    chk("t4_ufl", {63'd0, underflow}, 64'd1);
    chk("t4_mute", data_out, 64'd0);
    chk("t4_stream_off", {63'd0, streaming}, 64'd0);
    clear_flags = 1'b1;
    tick;
    clear_flags = 1'b0;
    chk("t4_ufl_clr", {63'd0, underflow}, 64'd0);
    for (int i = 0; i < 8; i++) begin
      op(1, 1, frame(400 + i), 1, 0);
      if (i == 6) begin
        chk("t4_fill_stream", {63'd0, streaming}, 64'd0);
        chk("t4_fill_ufl", {63'd0, underflow}, 64'd0);
        chk("t4_fill_level", {59'd0, level}, 64'd7);
      end
    end
    chk("t4_restream", {63'd0, streaming}, 64'd1);

    // 5: mixed traffic across pointer wrap against the scoreboard
    for (int i = 0; i < 40; i++) begin
      op((i % 3) != 2, (i % 2) == 1, frame(500 + i), (i % 3) != 2, (i % 2) == 1);
    end
    chk("t5_level_sb", {59'd0, level}, 64'(sb.size()));
    chk("t5_level15", {59'd0, level}, 64'd15);
    chk("t5_af", {63'd0, almost_full}, 64'd1);

    // 6: reset mid-read at level 10
    for (int i = 0; i < 5; i++) op(0, 1, '0, 0, 1);
    chk("t6_level10", {59'd0, level}, 64'd10);
    rst = 1'b1;
    read_en = 1'b1;
    tick;
    rst = 1'b0;
    read_en = 1'b0;
    sb.delete();
    chk("t6_level", {59'd0, level}, 64'd0);
    chk("t6_empty", {63'd0, empty}, 64'd1);
    chk("t6_vld", {63'd0, out_valid}, 64'd0);
    chk("t6_stream", {63'd0, streaming}, 64'd0);
    chk("t6_dout", data_out, 64'd0);
    op(1, 0, frame(777), 1, 0);
    op(0, 1, '0, 0, 0);
    chk("t6_filling_ufl", {63'd0, underflow}, 64'd0);
    chk("t6_filling_level", {59'd0, level}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
